// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier datapath blocks: the accumulator
// width helper and the accumulator state encoding.
package mult_pkg;

  typedef enum logic {ACCUM, HOLD} acc_state_e;

  // Accumulator width wide enough that len full-scale products never wrap.
  function automatic int acc_width(input int width, input int len);
    return 2 * width + $clog2(len);
  endfunction

endpackage

// File: rtl/mult_sat_counter.sv
// Saturating up-counter with synchronous clear. It sticks at all-ones and
// never wraps, so a long stall still reads as "very long".
module mult_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  // Clear wins over increment; increment stops at the all-ones value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/mult_accumulator.sv
// Dot-product accumulator. It sums LEN consecutive unsigned products and
// offers the total on a valid/ready port. While a finished total is waiting,
// the product side is held off unless the total is retired in the same cycle.
// Optional feature macro: MULT_ACC_STALL_CNT_EN adds a saturating stall_cnt
// output that counts enabled cycles where a result waits on acc_ready.
module mult_accumulator
  import mult_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int LEN         = 4,
  parameter int CHECK_PARAM = 1,
  localparam int ACC_W      = acc_width(WIDTH, LEN),
  localparam int CNT_W      = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clear,
  input  logic               prod_valid,
  input  logic [2*WIDTH-1:0] prod,
  output logic               prod_ready,
  output logic               acc_valid,
  output logic [ACC_W-1:0]   acc_data,
  input  logic               acc_ready,
  output logic [CNT_W-1:0]   acc_count
`ifdef MULT_ACC_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  // Reject parameter values that would make the width arithmetic meaningless.
  generate
    if (CHECK_PARAM != 0) begin : g_check
      if (LEN < 1 || WIDTH < 2) begin : g_bad
        $error("mult_accumulator: LEN must be >= 1 and WIDTH >= 2");
      end
    end
  endgenerate

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  acc_state_e       state_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] data_reg;
  logic [CNT_W-1:0] count_reg;
  logic             valid_reg;
  logic             beat_in;
  logic             beat_out;
  logic [ACC_W-1:0] sum_next;

  // Handshake decode; ready follows acc_ready so HOLD can retire and refill together.
  always_comb begin
    prod_ready = en & ~clear & ((state_reg == ACCUM) | acc_ready);
    beat_in    = prod_valid & prod_ready;
    beat_out   = valid_reg & acc_ready & en;
    sum_next   = acc_reg + ACC_W'(prod);
  end

  // FSM and datapath. In HOLD the partial sum is already zero, so an incoming
  // beat uses the same accumulate path as in ACCUM; that also covers LEN==1,
  // where the retire-and-refill beat immediately lands a new result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ACCUM;
      acc_reg   <= '0;
      data_reg  <= '0;
      count_reg <= '0;
      valid_reg <= 1'b0;
    end else if (clear) begin
      state_reg <= ACCUM;
      acc_reg   <= '0;
      count_reg <= '0;
      valid_reg <= 1'b0;
    end else if (en) begin
      if (beat_out) begin
        valid_reg <= 1'b0;
        state_reg <= ACCUM;
      end
      if (beat_in) begin
        if (count_reg == LAST_CNT) begin
          data_reg  <= sum_next;
          valid_reg <= 1'b1;
          acc_reg   <= '0;
          count_reg <= '0;
          state_reg <= HOLD;
        end else begin
          acc_reg   <= sum_next;
          count_reg <= count_reg + CNT_W'(1);
        end
      end
    end
  end

  assign acc_valid = valid_reg;
  assign acc_data  = data_reg;
  assign acc_count = count_reg;

`ifdef MULT_ACC_STALL_CNT_EN
  mult_sat_counter #(
    .WIDTH (16)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (en & valid_reg & ~acc_ready),
    .clr   (clear),
    .count (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_mult_accumulator.sv
// Self-checking bench for mult_accumulator (WIDTH=8, LEN=4, ACC_W=18).
// Directed table rows, a mid-run reset sequence and random traffic, all
// compared against a queue-based model of the dot-product behaviour.
module tb_mult_accumulator;

  localparam int WIDTH = 8;
  localparam int LEN   = 4;
  localparam int ACC_W = 18;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             clear;
  logic             prod_valid;
  logic [15:0]      prod;
  logic             prod_ready;
  logic             acc_valid;
  logic [ACC_W-1:0] acc_data;
  logic             acc_ready;
  logic [CNT_W-1:0] acc_count;
  logic [15:0]      stall_cnt;

  mult_accumulator #(
    .WIDTH       (WIDTH),
    .LEN         (LEN),
    .CHECK_PARAM (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clear      (clear),
    .prod_valid (prod_valid),
    .prod       (prod),
    .prod_ready (prod_ready),
    .acc_valid  (acc_valid),
    .acc_data   (acc_data),
    .acc_ready  (acc_ready),
    .acc_count  (acc_count)
`ifdef MULT_ACC_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: list of products in the current partial sum, plus the
  // last finished result and whether it is still waiting.
  int          m_part[$];
  logic [31:0] m_data;
  bit          m_valid;
  int          m_stall;

  typedef struct {
    bit          en, clr, pv, ar;
    logic [15:0] prod;
    bit          e_ready, e_valid;
    logic [31:0] e_data;
    int          e_count;
  } row_t;

  row_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return en && !clear && (!m_valid || acc_ready);
  endfunction

  task automatic model_reset();
    m_part.delete();
    m_data  = 0;
    m_valid = 0;
    m_stall = 0;
  endtask

  task automatic model_check();
    chk("prod_ready", {31'd0, prod_ready}, {31'd0, model_ready()});
    chk("acc_valid", {31'd0, acc_valid}, {31'd0, m_valid});
    chk("acc_data", 32'(acc_data), m_data);
    chk("acc_count", 32'(acc_count), 32'(m_part.size()));
`ifdef MULT_ACC_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
  endtask

  // Apply one clock edge worth of the current inputs to the model.
  task automatic model_update();
    bit rdy, bi, bo;
    int sum;
    rdy = model_ready();
    if (clear) begin
      m_part.delete();
      m_valid = 0;
      m_stall = 0;
    end else if (en) begin
      if (m_valid && !acc_ready && m_stall < 65535) m_stall++;
      bo = m_valid && acc_ready;
      bi = prod_valid && rdy;
      if (bo) m_valid = 0;
      if (bi) begin
        m_part.push_back(int'(prod));
        if (m_part.size() == LEN) begin
          sum = 0;
          foreach (m_part[k]) sum += m_part[k];
          m_data  = 32'(sum);
          m_valid = 1;
          m_part.delete();
        end
      end
    end
  endtask

  task automatic drive(input bit e, input bit c, input bit pv, input logic [15:0] p, input bit ar);
    en = e; clear = c; prod_valid = pv; prod = p; acc_ready = ar;
  endtask

  // One cycle: sample at the falling edge, then advance on the rising edge.
  task automatic step(input bit has_row, input row_t r);
    @(negedge clk);
    if (has_row) begin
      chk("tbl_ready", {31'd0, prod_ready}, {31'd0, r.e_ready});
      chk("tbl_valid", {31'd0, acc_valid}, {31'd0, r.e_valid});
      chk("tbl_data", 32'(acc_data), r.e_data);
      chk("tbl_count", 32'(acc_count), 32'(r.e_count));
    end
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic add(input bit e, input bit c, input bit pv, input logic [15:0] p, input bit ar,
                     input bit er, input bit ev, input logic [31:0] ed, input int ec);
    row_t r;
    r.en = e; r.clr = c; r.pv = pv; r.prod = p; r.ar = ar;
    r.e_ready = er; r.e_valid = ev; r.e_data = ed; r.e_count = ec;
    tbl.push_back(r);
  endtask

  row_t none;

  initial begin
    none = '{default: 0};
    rst = 1'b1;
    drive(1, 0, 0, 16'd0, 1);
    model_reset();
    #2;
    chk("rst_valid", {31'd0, acc_valid}, 32'd0);
    chk("rst_data", 32'(acc_data), 32'd0);
    chk("rst_count", 32'(acc_count), 32'd0);
    #20;
    rst = 1'b0;
    @(posedge clk); #1;

    // Expected outputs are those seen while the row's inputs are applied.
    // 3,5,7,9 -> 24
    add(1,0,1,16'd3,1,   1,0,0,0);
    add(1,0,1,16'd5,1,   1,0,0,1);
    add(1,0,1,16'd7,1,   1,0,0,2);
    add(1,0,1,16'd9,1,   1,0,0,3);
    add(1,0,0,16'd0,0,   0,1,24,0);
    add(1,0,0,16'd0,1,   1,1,24,0);
    // full-scale products -> 18'h3F804
    add(1,0,1,16'hFE01,1, 1,0,24,0);
    add(1,0,1,16'hFE01,1, 1,0,24,1);
    add(1,0,1,16'hFE01,1, 1,0,24,2);
    add(1,0,1,16'hFE01,1, 1,0,24,3);
    for (int i = 0; i < 5; i++) add(1,0,1,16'd77,0, 0,1,32'h3F804,0);
    // retire and start next sum in one cycle, then 1,1,1 -> 13
    add(1,0,1,16'd10,1,  1,1,32'h3F804,0);
    add(1,0,1,16'd1,1,   1,0,32'h3F804,1);
    add(1,0,1,16'd1,1,   1,0,32'h3F804,2);
    add(1,0,1,16'd1,1,   1,0,32'h3F804,3);
    add(0,0,0,16'd0,1,   0,1,13,0);
    add(1,0,0,16'd0,1,   1,1,13,0);
    // two beats, clear, frozen cycles, then 4 ones -> 4
    add(1,0,1,16'd2,1,   1,0,13,0);
    add(1,0,1,16'd2,1,   1,0,13,1);
    add(1,1,1,16'd5,1,   0,0,13,2);
    for (int i = 0; i < 3; i++) add(0,0,1,16'd7,1, 0,0,13,0);
    for (int i = 0; i < 4; i++) add(1,0,1,16'd1,1, 1,0,13,i);
    add(1,0,0,16'd0,1,   1,1,4,0);
    add(1,0,0,16'd0,1,   1,0,4,0);

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].clr, tbl[i].pv, tbl[i].prod, tbl[i].ar);
      step(1, tbl[i]);
    end

    // Clear while frozen in HOLD: result dropped, acc_data kept.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 16'(100 + i), 0);
      step(0, none);
    end
    drive(0, 1, 0, 16'd0, 0);
    step(0, none);
    drive(1, 0, 0, 16'd0, 0);
    step(0, none);

    // Mid-run asynchronous reset while a result is held.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 16'(200 + i), 0);
      step(0, none);
    end
    drive(1, 0, 0, 16'd0, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_valid", {31'd0, acc_valid}, 32'd0);
    chk("midrst_data", 32'(acc_data), 32'd0);
    chk("midrst_count", 32'(acc_count), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {31'd0, prod_ready}, 32'd1);
    @(posedge clk);
    model_update();
    #1;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 8) != 0, ($urandom % 50) == 0, $urandom % 2,
            16'($urandom_range(0, 16'hFFFF)), ($urandom % 3) != 0);
      step(0, none);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
